mem_arbiter: RTL and testbench

Shares the CPU's single SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM load/store path). Holds at most one outstanding transaction, grants data over instruction by default, and bounds instruction starvation with a streak counter. Sits between the pipeline stages and the top-level memory/bridge interface.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 54 +++++
 tb/tb_mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-port signals around the arbiter
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data-first with bounded fetch starvation
module mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input logic           clk,
    input logic           resetn,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
    state_t     state;
    logic       grant_data;
    logic [3:0] streak;
    logic       pick_data;
    logic       owner_req;
    logic       in_addr;
    logic       resp;
    always_comb begin
        pick_data = bus.data_req && !(bus.inst_req && streak == 4'(MAX_DATA_STREAK));
        owner_req = grant_data ? bus.data_req : bus.inst_req;
        in_addr   = resetn && state == ADDR;
        resp      = resetn && state == WAIT && bus.mem_data_ok;
    end
    // outputs gated by resetn so nothing leaks during the reset cycle itself
    assign bus.mem_req      = in_addr && owner_req;
    assign bus.mem_wr       = grant_data && bus.data_wr;
    assign bus.mem_size     = grant_data ? bus.data_size : 2'd2;
    assign bus.mem_wstrb    = grant_data ? bus.data_wstrb : 4'd0;
    assign bus.mem_addr     = grant_data ? bus.data_addr : bus.inst_addr;
    assign bus.mem_wdata    = grant_data ? bus.data_wdata : 32'd0;
    assign bus.inst_addr_ok = bus.mem_req && bus.mem_addr_ok && !grant_data;
    assign bus.data_addr_ok = bus.mem_req && bus.mem_addr_ok && grant_data;
    assign bus.inst_data_ok = resp && !grant_data;
    assign bus.data_data_ok = resp && grant_data;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant_data <= 1'b0;
            streak     <= 4'd0;
        end else begin
            case (state)
                IDLE: if (bus.inst_req || bus.data_req) begin
                    grant_data <= pick_data;
                    streak     <= (pick_data && bus.inst_req) ? streak + 4'd1 : 4'd0;
                    state      <= ADDR;
                end
                ADDR: state <= (bus.mem_req && bus.mem_addr_ok) ? WAIT : (!owner_req ? IDLE : ADDR);
                WAIT: state <= bus.mem_data_ok ? IDLE : WAIT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch, store, collision, starvation, withdraw and reset
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad = 0;

    mem_arbiter_if bus ();
    mem_arbiter #(.MAX_DATA_STREAK(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mreq"}, 32'(bus.mem_req), 0);
        chk({tag, "_iaok"}, 32'(bus.inst_addr_ok), 0);
        chk({tag, "_daok"}, 32'(bus.data_addr_ok), 0);
        chk({tag, "_idok"}, 32'(bus.inst_data_ok), 0);
        chk({tag, "_ddok"}, 32'(bus.data_data_ok), 0);
    endtask

    initial begin
        resetn = 1'b0;
        bus.inst_req = 0; bus.inst_addr = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;
        nx(); #1 chk("rst_mreq0", 32'(bus.mem_req), 0);
        nx(); #1 chk_quiet("rst");
        chk("rst_streak", 32'(dut.streak), 0);
        resetn = 1'b1;

        // single fetch
        nx(); bus.inst_req = 1; bus.inst_addr = 32'h1c000000;
        #1 chk("f_idle_mreq", 32'(bus.mem_req), 0);
        nx(); bus.mem_addr_ok = 1;
        #1 chk("f_mreq", 32'(bus.mem_req), 1);
        chk("f_maddr", bus.mem_addr, 32'h1c000000);
        chk("f_mwr", 32'(bus.mem_wr), 0);
        chk("f_msize", 32'(bus.mem_size), 2);
        chk("f_mwstrb", 32'(bus.mem_wstrb), 0);
        chk("f_iaok", 32'(bus.inst_addr_ok), 1);
        chk("f_daok", 32'(bus.data_addr_ok), 0);
        nx(); bus.inst_req = 0; bus.mem_addr_ok = 0;
        #1 chk("f_wait_mreq", 32'(bus.mem_req), 0);
        chk("f_wait_iaok", 32'(bus.inst_addr_ok), 0);
        chk("f_wait_idok", 32'(bus.inst_data_ok), 0);
        nx(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h02800c0c;
        #1 chk("f_idok", 32'(bus.inst_data_ok), 1);
        chk("f_rdata", bus.inst_rdata, 32'h02800c0c);
        chk("f_ddok", 32'(bus.data_data_ok), 0);
        nx(); bus.mem_data_ok = 0;
        #1 chk_quiet("f_end");

        // byte store
        nx(); bus.data_req = 1; bus.data_wr = 1; bus.data_size = 0; bus.data_wstrb = 4'b0100;
        bus.data_addr = 32'h1c010002; bus.data_wdata = 32'h00ab0000;
        #1 chk("s_idle_mreq", 32'(bus.mem_req), 0);
        nx(); bus.mem_addr_ok = 1;
        #1 chk("s_mreq", 32'(bus.mem_req), 1);
        chk("s_mwr", 32'(bus.mem_wr), 1);
        chk("s_msize", 32'(bus.mem_size), 0);
        chk("s_mwstrb", 32'(bus.mem_wstrb), 4'b0100);
        chk("s_maddr", bus.mem_addr, 32'h1c010002);
        chk("s_mwdata", bus.mem_wdata, 32'h00ab0000);
        chk("s_daok", 32'(bus.data_addr_ok), 1);
        chk("s_iaok", 32'(bus.inst_addr_ok), 0);
        nx(); bus.data_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 1; bus.mem_rdata = 0;
        #1 chk("s_ddok", 32'(bus.data_data_ok), 1);
        chk("s_idok", 32'(bus.inst_data_ok), 0);
        chk("s_daok_wait", 32'(bus.data_addr_ok), 0);
        nx(); bus.mem_data_ok = 0;
        #1 chk_quiet("s_end");
        chk("s_streak", 32'(dut.streak), 0);

        // collision: data first, inst after one idle cycle
        nx(); bus.inst_req = 1; bus.inst_addr = 32'h1c000004;
        bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_wstrb = 0; bus.data_addr = 32'h1c020000;
        #1 chk("c_idle_mreq", 32'(bus.mem_req), 0);
        nx(); bus.mem_addr_ok = 1;
        #1 chk("c_daok", 32'(bus.data_addr_ok), 1);
        chk("c_iaok", 32'(bus.inst_addr_ok), 0);
        chk("c_maddr", bus.mem_addr, 32'h1c020000);
        chk("c_streak1", 32'(dut.streak), 1);
        nx(); bus.data_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'h12345678;
        #1 chk("c_ddok", 32'(bus.data_data_ok), 1);
        chk("c_drdata", bus.data_rdata, 32'h12345678);
        chk("c_wait_mreq", 32'(bus.mem_req), 0);
        nx(); bus.mem_data_ok = 0;
        #1 chk("c_gap_mreq", 32'(bus.mem_req), 0);
        chk("c_gap_iaok", 32'(bus.inst_addr_ok), 0);
        nx(); bus.mem_addr_ok = 1;
        #1 chk("c_i_mreq", 32'(bus.mem_req), 1);
        chk("c_i_maddr", bus.mem_addr, 32'h1c000004);
        chk("c_i_iaok", 32'(bus.inst_addr_ok), 1);
        chk("c_streak0", 32'(dut.streak), 0);
        nx(); bus.inst_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 1;
        #1 chk("c_i_idok", 32'(bus.inst_data_ok), 1);
        chk("c_i_ddok", 32'(bus.data_data_ok), 0);
        nx(); bus.mem_data_ok = 0;

        // starvation bound: data x4 then inst; memory always ready
        for (int k = 0; k < 5; k++) begin
            nx();
            if (k == 0) begin
                bus.inst_req = 1; bus.data_req = 1; bus.mem_addr_ok = 1; bus.mem_data_ok = 1;
                bus.data_addr = 32'h1c040000;
            end
            #1 chk("st_idle_mreq", 32'(bus.mem_req), 0);
            chk("st_idle_idok", 32'(bus.inst_data_ok), 0);
            chk("st_idle_ddok", 32'(bus.data_data_ok), 0);
            nx(); #1 chk("st_mreq", 32'(bus.mem_req), 1);
            chk($sformatf("st_daok%0d", k), 32'(bus.data_addr_ok), 32'(k < 4));
            chk($sformatf("st_iaok%0d", k), 32'(bus.inst_addr_ok), 32'(k == 4));
            chk("st_addr_ddok", 32'(bus.data_data_ok), 0);
            chk("st_addr_idok", 32'(bus.inst_data_ok), 0);
            nx(); #1 chk("st_wait_mreq", 32'(bus.mem_req), 0);
            chk($sformatf("st_ddok%0d", k), 32'(bus.data_data_ok), 32'(k < 4));
            chk($sformatf("st_idok%0d", k), 32'(bus.inst_data_ok), 32'(k == 4));
        end
        nx(); bus.inst_req = 0; bus.data_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 0;
        #1 chk("st_streak", 32'(dut.streak), 0);
        chk_quiet("st_end");

        // withdraw data request while memory stalls
        nx(); bus.data_req = 1; bus.data_addr = 32'h1c030000; bus.inst_req = 1; bus.inst_addr = 32'h1c000008;
        #1 chk("w_idle_mreq", 32'(bus.mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            nx(); #1 chk("w_stall_mreq", 32'(bus.mem_req), 1);
            chk("w_stall_maddr", bus.mem_addr, 32'h1c030000);
            chk("w_stall_daok", 32'(bus.data_addr_ok), 0);
        end
        nx(); bus.data_req = 0;
        #1 chk_quiet("w_drop");
        nx(); #1 chk_quiet("w_idle");
        nx(); bus.mem_addr_ok = 1;
        #1 chk("w_i_mreq", 32'(bus.mem_req), 1);
        chk("w_i_maddr", bus.mem_addr, 32'h1c000008);
        chk("w_i_iaok", 32'(bus.inst_addr_ok), 1);
        nx(); bus.inst_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 1;
        #1 chk("w_i_idok", 32'(bus.inst_data_ok), 1);
        chk("w_i_ddok", 32'(bus.data_data_ok), 0);
        nx(); bus.mem_data_ok = 0;

        // reset during WAIT drops the late response
        nx(); bus.inst_req = 1; bus.inst_addr = 32'h1c00000c;
        nx(); bus.mem_addr_ok = 1;
        #1 chk("r_iaok", 32'(bus.inst_addr_ok), 1);
        nx(); bus.inst_req = 0; bus.mem_addr_ok = 0;
        #1 chk("r_wait_mreq", 32'(bus.mem_req), 0);
        nx(); resetn = 0; bus.mem_data_ok = 1;
        #1 chk_quiet("r_inrst");
        nx(); resetn = 1;
        #1 chk_quiet("r_late");
        chk("r_streak", 32'(dut.streak), 0);
        nx(); bus.mem_data_ok = 0;
        #1 chk_quiet("r_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
